// File: rtl/hamming_distance_unit.sv
// ---------------------------------------------------------------------------
// hamming_distance_unit
//
// Upstream feeder of the ALU distance path. A 1024-bit Skein hash arrives
// as NUM_WORDS beats of WORD_W bits, word 0 first, each beat paired with the
// matching target word. Every accepted beat is XORed with its target and
// popcounted. The per-beat counts are summed, and one saturated DIST_W-bit
// Hamming distance is produced per hash, together with a one-cycle done
// pulse. A downstream secondary register latches distance_o on done_o.
//
// Optional feature macro: HDU_EARLY_ABORT_EN
//   defined   : the run is abandoned as soon as the running sum reaches
//               bound_i. The result is then 1023 with aborted_o = 1.
//   undefined : bound_i is ignored, aborted_o is tied low, and all
//               NUM_WORDS beats are always consumed.
//
// Ports
//   clk_i          in   1       clock, all state on rising edge
//   rst_n_i        in   1       asynchronous active-low reset
//   start_i        in   1       begin new hash (honoured only in IDLE)
//   word_valid_i   in   1       hash_word_i/target_word_i valid
//   word_ready_o   out  1       unit accepts a beat this cycle (ACCUM)
//   hash_word_i    in   WORD_W  hash beat
//   target_word_i  in   WORD_W  target beat aligned with hash_word_i
//   bound_i        in   DIST_W  early-abort bound
//   busy_o         out  1       high in ACCUM and DONE
//   done_o         out  1       one-cycle pulse, distance_o valid
//   distance_o     out  DIST_W  last completed distance, held until next done
//   aborted_o      out  1       qualifies done_o: run was cut short
// ---------------------------------------------------------------------------
module hamming_distance_unit #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned DIST_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic [WORD_W-1:0] hash_word_i,
  input  logic [WORD_W-1:0] target_word_i,
  input  logic [DIST_W-1:0] bound_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DIST_W-1:0] distance_o,
  output logic              aborted_o
);

  // One extra bit so the true maximum (1024) is representable before
  // saturation.
  localparam int unsigned ACC_W = DIST_W + 1;
  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned POP_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;

  logic [POP_W-1:0]  beat_pop;
  logic [ACC_W-1:0]  acc_sum;
  logic [DIST_W-1:0] acc_sat;
  logic              beat_fire;
  logic              last_beat;

  function automatic logic [POP_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  // --------------------------------------------------------------------
  // Datapath: per-beat popcount and running sum
  // --------------------------------------------------------------------
  assign beat_fire = word_valid_i && (state_q == S_ACCUM);
  assign last_beat = (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign beat_pop  = popcount(hash_word_i ^ target_word_i);
  assign acc_sum   = acc_q + ACC_W'(beat_pop);
  // Any value with the top accumulator bit set exceeds the output range.
  assign acc_sat   = acc_sum[ACC_W-1] ? '1 : acc_sum[DIST_W-1:0];

`ifdef HDU_EARLY_ABORT_EN
  logic abort_q, abort_d;
  logic abort_hit;

  assign abort_hit = (acc_sum >= {1'b0, bound_i});
`else
  logic unused_bound;

  assign unused_bound = ^bound_i;
`endif

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
`ifdef HDU_EARLY_ABORT_EN
    abort_d = abort_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (beat_fire) begin
          acc_d = acc_sum;
          cnt_d = last_beat ? '0 : cnt_q + 1'b1;
`ifdef HDU_EARLY_ABORT_EN
          // The bound check wins over normal completion, so a run that
          // reaches the bound on its final beat still reports an abort.
          if (abort_hit) begin
            cnt_d   = '0;
            dist_d  = '1;
            abort_d = 1'b1;
            state_d = S_DONE;
          end else if (last_beat) begin
            dist_d  = acc_sat;
            abort_d = 1'b0;
            state_d = S_DONE;
          end
`else
          if (last_beat) begin
            dist_d  = acc_sat;
            state_d = S_DONE;
          end
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
    end
  end

`ifdef HDU_EARLY_ABORT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end

  assign aborted_o = abort_q;
`else
  assign aborted_o = 1'b0;
`endif

  // --------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // --------------------------------------------------------------------
  assign word_ready_o = (state_q == S_ACCUM);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign distance_o   = dist_q;

endmodule

// File: tb/tb_hamming_distance_unit.sv
module tb_hamming_distance_unit;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [63:0] hash_word_i;
  logic [63:0] target_word_i;
  logic [9:0]  bound_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  distance_o;
  logic        aborted_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hamming_distance_unit #(
    .WORD_W   (64),
    .NUM_WORDS(16),
    .DIST_W   (10)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .hash_word_i  (hash_word_i),
    .target_word_i(target_word_i),
    .bound_i      (bound_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .distance_o   (distance_o),
    .aborted_o    (aborted_o)
  );

  // k        : differing bits per beat
  // gap      : word_valid_i only on alternate cycles
  // poke     : start_i pulsed mid-run and in the DONE cycle
  // exp_beats: beats accepted before done_o
  typedef struct {
    int unsigned k;
    bit          gap;
    bit          poke;
    logic [9:0]  bound;
    logic [9:0]  exp_dist;
    bit          exp_ab;
    int unsigned exp_beats;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int unsigned k, bit gap, bit poke, logic [9:0] bound,
                              logic [9:0] exp_dist, bit exp_ab, int unsigned exp_beats);
    vec_t v;
    v.k = k; v.gap = gap; v.poke = poke; v.bound = bound;
    v.exp_dist = exp_dist; v.exp_ab = exp_ab; v.exp_beats = exp_beats;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] tgt, msk, m;
    int unsigned beat, rr;
    int          cyc;
    bit          got_done, busy_bad, pend;
    string       t;
    t = $sformatf("v%0d", idx);
    bound_i      = v.bound;
    word_valid_i = 1'b0;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    cyc      = 2;
    beat     = 0;
    got_done = 1'b0;
    busy_bad = 1'b0;
    msk = (v.k >= 64) ? '1 : ((64'd1 << v.k) - 64'd1);
    while (cyc < 60) begin
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      if (!busy_o) busy_bad = 1'b1;
      tgt = {$urandom, $urandom};
      rr  = (beat * 5) % 64;
      m   = (msk << rr) | (msk >> (64 - rr));
      target_word_i = tgt;
      hash_word_i   = tgt ^ m;
      word_valid_i  = v.gap ? (cyc % 2 == 1) : 1'b1;
      start_i       = v.poke && (cyc == 8);
      pend          = word_valid_i && word_ready_o;
      @(posedge clk); #1;
      if (pend) beat++;
      cyc++;
    end
    start_i = 1'b0;
    chk({t, "_done_seen"}, {31'd0, got_done}, 32'd1);
    if (got_done) begin
      chk({t, "_distance"}, {22'd0, distance_o}, {22'd0, v.exp_dist});
      chk({t, "_aborted"}, {31'd0, aborted_o}, {31'd0, v.exp_ab});
      chk({t, "_beats"}, beat, v.exp_beats);
      chk({t, "_busy_run"}, {31'd0, busy_bad}, 32'd0);
      chk({t, "_busy_done"}, {31'd0, busy_o}, 32'd1);
      chk({t, "_ready_done"}, {31'd0, word_ready_o}, 32'd0);
      if (!v.gap) chk({t, "_latency"}, cyc, v.exp_beats + 2);
      // valid (and optionally start) during DONE must be ignored
      word_valid_i = 1'b1;
      start_i      = v.poke;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk({t, "_done_width"}, {31'd0, done_o}, 32'd0);
      chk({t, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
      chk({t, "_dist_held"}, {22'd0, distance_o}, {22'd0, v.exp_dist});
      @(posedge clk); #1;
      word_valid_i = 1'b0;
      if (v.poke) chk({t, "_start_in_done_ignored"}, {31'd0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    int unsigned beat;
    int          seen;

    vecs.push_back(mk(0,  0, 0, 10'd1023, 10'd0,    1'b0, 16));
`ifdef HDU_EARLY_ABORT_EN
    vecs.push_back(mk(64, 0, 0, 10'd1023, 10'd1023, 1'b1, 16));
`else
    vecs.push_back(mk(64, 0, 0, 10'd1023, 10'd1023, 1'b0, 16));
`endif
    vecs.push_back(mk(3,  1, 1, 10'd1023, 10'd48,   1'b0, 16));
    vecs.push_back(mk(1,  0, 0, 10'd1023, 10'd16,   1'b0, 16));
    vecs.push_back(mk(63, 0, 0, 10'd1023, 10'd1008, 1'b0, 16));
    vecs.push_back(mk(32, 1, 0, 10'd1023, 10'd512,  1'b0, 16));
    vecs.push_back(mk(5,  0, 1, 10'd1023, 10'd80,   1'b0, 16));
`ifdef HDU_EARLY_ABORT_EN
    vecs.push_back(mk(40, 0, 0, 10'd100,  10'd1023, 1'b1, 3));
    vecs.push_back(mk(0,  0, 0, 10'd0,    10'd1023, 1'b1, 1));
    vecs.push_back(mk(64, 0, 0, 10'd64,   10'd1023, 1'b1, 1));
    vecs.push_back(mk(40, 1, 0, 10'd1023, 10'd640,  1'b0, 16));
`endif

    rst_n_i       = 1'b0;
    start_i       = 1'b1;
    word_valid_i  = 1'b1;
    hash_word_i   = '1;
    target_word_i = '0;
    bound_i       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",    {31'd0, word_ready_o}, 32'd0);
    chk("rst_busy",     {31'd0, busy_o},       32'd0);
    chk("rst_done",     {31'd0, done_o},       32'd0);
    chk("rst_distance", {22'd0, distance_o},   32'd0);
    chk("rst_aborted",  {31'd0, aborted_o},    32'd0);
    start_i = 1'b0;
    #2 rst_n_i = 1'b1;
    // valid in IDLE without start is ignored
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid_busy", {31'd0, busy_o}, 32'd0);
    word_valid_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Asynchronous reset after beat 7 of a run (4 bits/beat).
    bound_i      = 10'd1023;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i      = 1'b0;
    beat         = 0;
    word_valid_i = 1'b1;
    target_word_i = 64'h0123_4567_89ab_cdef;
    hash_word_i   = 64'h0123_4567_89ab_cdef ^ 64'hf;
    while (beat < 8) begin
      @(posedge clk); #1;
      beat++;
    end
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_ready",    {31'd0, word_ready_o}, 32'd0);
    chk("arst_busy",     {31'd0, busy_o},       32'd0);
    chk("arst_done",     {31'd0, done_o},       32'd0);
    chk("arst_distance", {22'd0, distance_o},   32'd0);
    chk("arst_aborted",  {31'd0, aborted_o},    32'd0);
    #2 rst_n_i = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    word_valid_i = 1'b0;
    chk("arst_no_done", seen, 0);
    chk("arst_idle", {31'd0, busy_o}, 32'd0);
    run_vec(mk(2, 0, 0, 10'd1023, 10'd32, 1'b0, 16), 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
